rc4_encryptor: RTL and testbench
================================

Name: rc4_encryptor

Overview:
- Encryption counterpart of the RC4 decryption datapath.
- Runs the RC4 PRGA over an already key-scheduled S RAM, reads plaintext bytes from a plaintext ROM, XORs each with the keystream, and writes ciphertext to a cipher RAM.
- Rejects plaintext outside the accepted alphabet (lowercase a-z, space), which is the same alphabet the decryptor's success check accepts. Every ciphertext it produces therefore round-trips through the decryptor with success.

Parameters:
- RAM_WIDTH, 8, data width of S, plaintext and cipher memories.
- RAM_LENGTH, 8, S RAM address width (S has 2^RAM_LENGTH entries).
- MESSAGE_LENGTH, 32, number of bytes encrypted per run (>=1).
- MESSAGE_LOG_LENGTH, 5, address width of plaintext ROM and cipher RAM.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level input; a run begins on its rising edge (internal edge detect: sampled high this cycle, low previous cycle).
- sOut  in  RAM_WIDTH  S RAM read data; registered read, valid the cycle after sAddr is presented.
- sIn  out  RAM_WIDTH  S RAM write data.
- sAddr  out  RAM_LENGTH  S RAM address.
- sWren  out  1  S RAM write enable.
- pOut  in  RAM_WIDTH  plaintext ROM data; registered read.
- pAddr  out  MESSAGE_LOG_LENGTH  plaintext ROM address; always equals k.
- cIn  out  RAM_WIDTH  cipher RAM write data, = sOut ^ pOut.
- cAddr  out  MESSAGE_LOG_LENGTH  cipher RAM address; always equals k.
- cWren  out  1  cipher RAM write enable.
- finished  out  1  one-cycle pulse at end of run (pass or fail).
- success  out  1  valid only while finished=1; 1 means all MESSAGE_LENGTH bytes were encrypted.

Behaviour:
- Registers: state, i, j (RAM_LENGTH bits), si, sj (RAM_WIDTH bits), k (MESSAGE_LOG_LENGTH bits).
- Reset: all registers cleared, state IDLE. All outputs are 0 in IDLE: sWren, cWren, finished, success, sAddr, sIn.
- Reset mid-run aborts immediately. No RAM write is issued in the cycle reset is high (wren outputs gated by reset). No finished pulse is produced.
- States and actions (one cycle each):
  - IDLE: wait for start rising edge -> INC_I. A start edge in any other state is ignored.
  - INC_I: i <= i+1; sAddr = i+1 -> READ_SI.
  - READ_SI: si <= sOut; j <= j + sOut (mod 2^RAM_LENGTH); sAddr = j + sOut -> READ_SJ.
  - READ_SJ: sj <= sOut; sAddr = i -> WRITE_SI.
  - WRITE_SI: sWren=1, sAddr=i, sIn=sj -> WRITE_SJ.
  - WRITE_SJ: sWren=1, sAddr=j, sIn=si -> READ_F.
  - READ_F: sAddr = si + sj (mod 2^RAM_LENGTH) -> WRITE_C.
  - WRITE_C: keystream byte is sOut.
    - pOut valid (0x61..0x7A or 0x20): cWren=1, cIn = sOut ^ pOut. If k < MESSAGE_LENGTH-1: k <= k+1, go to INC_I; else go to DONE_OK.
    - pOut invalid: cWren=0, go to DONE_FAIL.
  - DONE_OK: finished=1, success=1 -> IDLE.
  - DONE_FAIL: finished=1, success=0 -> IDLE.
  - On entry to DONE_*: i, j, si, sj, k cleared.
- Latency: 7 cycles per byte. With start first sampled high in cycle 0, finished=1 in cycle 7*MESSAGE_LENGTH+1.
- Swap with i==j: both writes carry the same value; S is unchanged. This is correct behaviour.
- i, j and si+sj wrap modulo 2^RAM_LENGTH. k never exceeds MESSAGE_LENGTH-1.
- S is left permuted after a run. The caller must rerun key scheduling before the next run; the block does not restore S.

Test Plan:
- Identity S (S[x]=x), MESSAGE_LENGTH=3, plaintext "abc" (61,62,63), start pulse -> keystream 02,05,07. Cipher RAM = 63,67,64. finished=success=1 in cycle 22. Afterwards S[2]=3, S[3]=5, S[5]=2, S[1]=1.
- Identity S, plaintext 61,42,63 -> cipher[0]=63 written. No cWren at k=1, cipher[1..2] untouched. finished=1, success=0 in cycle 15.
- Reset asserted during WRITE_SJ of byte 1 -> no sWren/cWren that cycle, state IDLE next cycle, no finished pulse, all outputs 0.
- start held high across a whole run plus 10 cycles -> exactly one run, one finished pulse. A second run starts only after start goes low, then high.
- Round trip: run KSA with key 00 01 02, encrypt "hello world", rerun KSA, decrypt the cipher RAM with the decryptor -> decrypted bytes equal the plaintext, decryptor success=1.
- Plaintext space (0x20) and boundary letters 0x61, 0x7A accepted; 0x60 and 0x7B rejected with success=0.

Source files
------------

// File: rtl/rc4_encryptor.sv
// rtl/rc4_encryptor.sv - RC4 PRGA encryptor: keystream from a key-scheduled S RAM XOR plaintext ROM into cipher RAM.
// Plaintext outside lowercase a-z and space aborts the run with success=0.
module rc4_encryptor #(
    parameter int RAM_WIDTH          = 8,
    parameter int RAM_LENGTH         = 8,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [RAM_WIDTH-1:0]          sOut,
    output logic [RAM_WIDTH-1:0]          sIn,
    output logic [RAM_LENGTH-1:0]         sAddr,
    output logic                          sWren,
    input  logic [RAM_WIDTH-1:0]          pOut,
    output logic [MESSAGE_LOG_LENGTH-1:0] pAddr,
    output logic [RAM_WIDTH-1:0]          cIn,
    output logic [MESSAGE_LOG_LENGTH-1:0] cAddr,
    output logic                          cWren,
    output logic                          finished,
    output logic                          success
);

    typedef enum logic [3:0] {
        IDLE,
        INC_I,
        READ_SI,
        READ_SJ,
        WRITE_SI,
        WRITE_SJ,
        READ_F,
        WRITE_C,
        DONE_OK,
        DONE_FAIL
    } state_t;

    localparam logic [MESSAGE_LOG_LENGTH-1:0] K_LAST = MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1);
    localparam logic [RAM_WIDTH-1:0] CH_SPACE = RAM_WIDTH'(8'h20);
    localparam logic [RAM_WIDTH-1:0] CH_LO    = RAM_WIDTH'(8'h61);
    localparam logic [RAM_WIDTH-1:0] CH_HI    = RAM_WIDTH'(8'h7A);

    state_t                        state;
    logic [RAM_LENGTH-1:0]         i;
    logic [RAM_LENGTH-1:0]         j;
    logic [RAM_WIDTH-1:0]          si;
    logic [RAM_WIDTH-1:0]          sj;
    logic [MESSAGE_LOG_LENGTH-1:0] k;
    logic                          start_d;

    logic                          start_edge;
    logic                          pt_valid;
    logic [RAM_LENGTH-1:0]         sout_addr;
    logic                          s_wren_raw;
    logic                          c_wren_raw;

    assign start_edge = start & ~start_d;
    assign pt_valid   = (pOut == CH_SPACE) || ((pOut >= CH_LO) && (pOut <= CH_HI));
    assign sout_addr  = RAM_LENGTH'(sOut);

    assign pAddr = k;
    assign cAddr = k;
    assign cIn   = sOut ^ pOut;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            i       <= '0;
            j       <= '0;
            si      <= '0;
            sj      <= '0;
            k       <= '0;
            start_d <= 1'b0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (start_edge) state <= INC_I;
                end
                INC_I: begin
                    i     <= i + RAM_LENGTH'(1);
                    state <= READ_SI;
                end
                READ_SI: begin
                    si    <= sOut;
                    j     <= j + sout_addr;
                    state <= READ_SJ;
                end
                READ_SJ: begin
                    sj    <= sOut;
                    state <= WRITE_SI;
                end
                WRITE_SI: state <= WRITE_SJ;
                WRITE_SJ: state <= READ_F;
                READ_F:   state <= WRITE_C;
                WRITE_C: begin
                    if (pt_valid && (k < K_LAST)) begin
                        k     <= k + MESSAGE_LOG_LENGTH'(1);
                        state <= INC_I;
                    end else begin
                        // Registers are cleared on the way into either DONE state.
                        i     <= '0;
                        j     <= '0;
                        si    <= '0;
                        sj    <= '0;
                        k     <= '0;
                        state <= pt_valid ? DONE_OK : DONE_FAIL;
                    end
                end
                DONE_OK:   state <= IDLE;
                DONE_FAIL: state <= IDLE;
                default:   state <= IDLE;
            endcase
        end
    end

    always_comb begin
        sAddr      = '0;
        sIn        = '0;
        s_wren_raw = 1'b0;
        c_wren_raw = 1'b0;
        case (state)
            INC_I:   sAddr = i + RAM_LENGTH'(1);
            READ_SI: sAddr = j + sout_addr;
            READ_SJ: sAddr = i;
            WRITE_SI: begin
                s_wren_raw = 1'b1;
                sAddr      = i;
                sIn        = sj;
            end
            WRITE_SJ: begin
                s_wren_raw = 1'b1;
                sAddr      = j;
                sIn        = si;
            end
            READ_F:  sAddr = RAM_LENGTH'(si) + RAM_LENGTH'(sj);
            WRITE_C: c_wren_raw = pt_valid;
            default: ;
        endcase
    end

    // Write enables are gated so an aborting reset never lands a partial swap or byte.
    assign sWren    = s_wren_raw & ~reset;
    assign cWren    = c_wren_raw & ~reset;
    assign finished = ((state == DONE_OK) || (state == DONE_FAIL)) & ~reset;
    assign success  = (state == DONE_OK) & ~reset;

endmodule

// File: tb/tb_rc4_encryptor.sv
// tb/tb_rc4_encryptor.sv - self-checking bench for rc4_encryptor against an array-based RC4 model.
module tb_rc4_encryptor;

    localparam int W   = 8;
    localparam int L   = 8;
    localparam int ML  = 11;
    localparam int MLL = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic [W-1:0]   sOut;
    logic [W-1:0]   sIn;
    logic [L-1:0]   sAddr;
    logic           sWren;
    logic [W-1:0]   pOut;
    logic [MLL-1:0] pAddr;
    logic [W-1:0]   cIn;
    logic [MLL-1:0] cAddr;
    logic           cWren;
    logic           finished;
    logic           success;

    rc4_encryptor #(
        .RAM_WIDTH(W), .RAM_LENGTH(L), .MESSAGE_LENGTH(ML), .MESSAGE_LOG_LENGTH(MLL)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .sOut(sOut), .sIn(sIn), .sAddr(sAddr), .sWren(sWren),
        .pOut(pOut), .pAddr(pAddr),
        .cIn(cIn), .cAddr(cAddr), .cWren(cWren),
        .finished(finished), .success(success)
    );

    always #5 clk = ~clk;

    logic [7:0] s_mem [256];
    logic [7:0] p_rom [16];
    logic [7:0] c_ram [16];

    always @(posedge clk) begin
        sOut <= s_mem[sAddr];
        pOut <= p_rom[pAddr];
        if (sWren) s_mem[sAddr] <= sIn;
        if (cWren) c_ram[cAddr] <= cIn;
    end

    int fin_count = 0;
    always @(negedge clk) if (finished) fin_count++;

    int total  = 0;
    int passed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: plain RC4 on arrays.
    logic [7:0] m_s [256];
    logic [7:0] m_c [16];
    bit         m_ok;
    int         m_fail;

    function automatic bit ok_char(input logic [7:0] b);
        return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7a);
    endfunction

    function automatic logic [7:0] rand_char();
        int r;
        r = $urandom_range(0, 26);
        return (r == 26) ? 8'h20 : 8'(8'h61 + r);
    endfunction

    task automatic model_run();
        int mi, mj;
        logic [7:0] t, ks;
        mi = 0; mj = 0; m_ok = 1; m_fail = -1;
        for (int n = 0; n < ML; n++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(m_s[mi])) % 256;
            t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
            ks = m_s[(int'(m_s[mi]) + int'(m_s[mj])) % 256];
            if (!ok_char(p_rom[n])) begin
                m_ok = 0; m_fail = n;
                break;
            end
            m_c[n] = p_rom[n] ^ ks;
        end
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_mem[x] = 8'(x);
    endtask

    task automatic load_perm();
        int r;
        logic [7:0] t;
        load_identity();
        for (int x = 255; x > 0; x--) begin
            r = $urandom_range(0, x);
            t = s_mem[x]; s_mem[x] = s_mem[r]; s_mem[r] = t;
        end
    endtask

    task automatic load_ksa();
        int kj;
        logic [7:0] t;
        load_identity();
        kj = 0;
        for (int x = 0; x < 256; x++) begin
            kj = (kj + int'(s_mem[x]) + (x % 3)) % 256;
            t = s_mem[x]; s_mem[x] = s_mem[kj]; s_mem[kj] = t;
        end
    endtask

    task automatic clear_cipher();
        for (int x = 0; x < 16; x++) c_ram[x] = 8'hEE;
    endtask

    task automatic run(input bit hold, output int cyc, output logic succ);
        @(negedge clk);
        start = 1'b1;
        cyc = -1; succ = 1'bx;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (c == 1 && !hold) start = 1'b0;
            if (finished) begin
                cyc = c; succ = success;
                break;
            end
        end
    endtask

    task automatic do_run(input string tag);
        int cyc, bad;
        logic succ;
        for (int x = 0; x < 256; x++) m_s[x] = s_mem[x];
        for (int x = 0; x < 16; x++) m_c[x] = c_ram[x];
        model_run();
        run(1'b0, cyc, succ);
        chk({tag, " finish_cycle"}, cyc, m_ok ? 7 * ML + 1 : 7 * m_fail + 8);
        chk({tag, " success"}, {31'd0, succ}, {31'd0, m_ok});
        @(posedge clk); #1;
        for (int x = 0; x < ML; x++) chk($sformatf("%s cipher[%0d]", tag, x), c_ram[x], m_c[x]);
        bad = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== m_s[x]) bad++;
        chk({tag, " s_ram_mismatches"}, bad, 0);
    endtask

    initial begin
        int cyc, f0, idx, kj, mi, mj;
        logic succ;
        logic [7:0] t, ks, hello [11];

        reset = 1'b1; start = 1'b0;
        load_identity();
        clear_cipher();
        for (int x = 0; x < 16; x++) p_rom[x] = 8'h61;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {sWren, cWren, finished, success, sAddr, sIn}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle outputs", {sWren, cWren, finished, success, sAddr, sIn}, 0);

        // "abc" on identity S: known keystream 02 05 07.
        load_identity(); clear_cipher();
        p_rom[0] = 8'h61; p_rom[1] = 8'h62; p_rom[2] = 8'h63;
        for (int x = 3; x < ML; x++) p_rom[x] = rand_char();
        do_run("abc");
        chk("abc c0", c_ram[0], 8'h63);
        chk("abc c1", c_ram[1], 8'h67);
        chk("abc c2", c_ram[2], 8'h64);

        // Invalid byte at k=1.
        load_identity(); clear_cipher();
        p_rom[0] = 8'h61; p_rom[1] = 8'h42; p_rom[2] = 8'h63;
        do_run("bad_k1");
        chk("bad_k1 c0", c_ram[0], 8'h63);
        chk("bad_k1 c1 untouched", c_ram[1], 8'hEE);
        chk("bad_k1 c2 untouched", c_ram[2], 8'hEE);

        // Random permutations and random plaintext, occasionally with a stray byte.
        for (int r = 0; r < 4; r++) begin
            load_perm(); clear_cipher();
            for (int x = 0; x < ML; x++) p_rom[x] = rand_char();
            if (r >= 2) p_rom[$urandom_range(0, ML - 1)] = 8'($urandom_range(0, 255));
            do_run($sformatf("rand%0d", r));
        end

        // Alphabet boundaries.
        load_perm(); clear_cipher();
        for (int x = 0; x < ML; x++) begin
            case ($urandom_range(0, 2))
                0: p_rom[x] = 8'h20;
                1: p_rom[x] = 8'h61;
                default: p_rom[x] = 8'h7a;
            endcase
        end
        do_run("bounds_ok");
        load_perm(); clear_cipher();
        idx = $urandom_range(0, ML - 1);
        p_rom[idx] = 8'h60;
        do_run("reject_60");
        load_perm(); clear_cipher();
        for (int x = 0; x < ML; x++) p_rom[x] = 8'h7a;
        p_rom[ML - 1] = 8'h7b;
        do_run("reject_7b");

        // Reset during WRITE_SJ of byte 1 (cycle 12).
        load_identity(); clear_cipher();
        for (int x = 0; x < ML; x++) p_rom[x] = 8'h61;
        f0 = fin_count;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("abort sWren gated", sWren, 0);
        chk("abort cWren gated", cWren, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort idle outputs", {sWren, cWren, finished, success, sAddr, sIn}, 0);
        repeat (30) @(posedge clk);
        #1;
        chk("abort no finish", fin_count - f0, 0);
        chk("abort S[2] swapped", s_mem[2], 8'h03);
        chk("abort S[3] unwritten", s_mem[3], 8'h03);
        chk("abort still idle", {sWren, sAddr}, 0);

        // start held high: one run only, until a new rising edge.
        load_identity(); clear_cipher();
        f0 = fin_count;
        run(1'b1, cyc, succ);
        chk("held finish_cycle", cyc, 7 * ML + 1);
        repeat (10 + 7 * ML) @(posedge clk);
        #1;
        chk("held one pulse", fin_count - f0, 1);
        start = 1'b0;
        repeat (2) @(posedge clk);
        load_identity();
        run(1'b0, cyc, succ);
        chk("rearm finish_cycle", cyc, 7 * ML + 1);
        @(posedge clk); #1;
        chk("rearm two pulses", fin_count - f0, 2);

        // Round trip with key 00 01 02 and "hello world".
        hello = '{8'h68, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h77, 8'h6f, 8'h72, 8'h6c, 8'h64};
        for (int x = 0; x < ML; x++) p_rom[x] = hello[x];
        load_ksa(); clear_cipher();
        do_run("hello");
        load_ksa();
        for (int x = 0; x < 256; x++) m_s[x] = s_mem[x];
        mi = 0; mj = 0; kj = 0;
        for (int n = 0; n < ML; n++) begin
            mi = (mi + 1) % 256;
            mj = (mj + int'(m_s[mi])) % 256;
            t = m_s[mi]; m_s[mi] = m_s[mj]; m_s[mj] = t;
            ks = m_s[(int'(m_s[mi]) + int'(m_s[mj])) % 256];
            chk($sformatf("roundtrip[%0d]", n), c_ram[n] ^ ks, hello[n]);
            if (!ok_char(c_ram[n] ^ ks)) kj++;
        end
        chk("roundtrip decrypt success", kj, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
